// File: rtl/vfu_slot_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : vfu_slot_arbiter
// Description : Shares one vector functional unit issue port between
//               NUM_SLOTS lane slot requesters. A round-robin grant loads a
//               registered output slice. In-flight requests are bounded by a
//               credit counter. VFU responses are routed back to the
//               originating slot by tag. `reset` is asynchronous, active-low.
//               Optional build macro VFU_ARB_LOCK_EN adds req_lock, which
//               lets the last granted slot keep the grant across beats.
// Revision    : 1.0 - initial release
// ============================================================================
module vfu_slot_arbiter #(
    parameter int NUM_SLOTS       = 4,
    parameter int REQ_W           = 200,
    parameter int RSP_W           = 33,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_SLOTS-1:0]         req_valid,
    output logic [NUM_SLOTS-1:0]         req_ready,
    input  logic [NUM_SLOTS*REQ_W-1:0]   req_bits,
`ifdef VFU_ARB_LOCK_EN
    input  logic [NUM_SLOTS-1:0]         req_lock,
`endif
    output logic                         vfu_valid,
    input  logic                         vfu_ready,
    output logic [REQ_W-1:0]             vfu_bits,
    output logic [1:0]                   vfu_tag,
    input  logic                         rsp_valid,
    input  logic [1:0]                   rsp_tag,
    input  logic [RSP_W-1:0]             rsp_data,
    output logic [NUM_SLOTS-1:0]         slot_rsp_valid,
    output logic [RSP_W-1:0]             slot_rsp_data,
    output logic [3:0]                   outstanding,
    output logic                         err_underflow
);

    // Slot index travels as a fixed 2-bit tag; the search sum needs one
    // extra bit to detect wrap-around.
    localparam int             c_TAG_W = 2;
    localparam int             c_SUM_W = c_TAG_W + 1;
    localparam logic [c_SUM_W-1:0] c_NUM_SLOTS = c_SUM_W'(NUM_SLOTS);
    localparam logic [4:0]     c_MAX   = 5'(MAX_OUTSTANDING);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                   r_vfu_valid;
    logic [REQ_W-1:0]       r_vfu_bits;
    logic [c_TAG_W-1:0]     r_vfu_tag;
    logic [c_TAG_W-1:0]     r_rr_ptr;
    logic [3:0]             r_outstanding;
    logic                   r_err_underflow;
    logic [NUM_SLOTS-1:0]   r_slot_rsp_valid;
    logic [RSP_W-1:0]       r_slot_rsp_data;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic                   w_can_load;
    logic                   w_vfu_fire;
    logic                   w_credit_ok;
    logic                   w_can_issue;
    logic [c_SUM_W-1:0]     w_sum;
    logic                   w_rr_found;
    logic [c_TAG_W-1:0]     w_rr_grant;
    logic                   w_found;
    logic [c_TAG_W-1:0]     w_grant;
    logic                   w_accept;
    logic [NUM_SLOTS-1:0]   w_req_ready;
    logic [REQ_W-1:0]       w_grant_bits;
    logic [c_TAG_W-1:0]     w_ptr_next;
    logic                   w_rsp_dec;
    logic                   w_rsp_underflow;
    logic [NUM_SLOTS-1:0]   w_rsp_onehot;

    // The output slice can take a new beat when empty or draining this cycle.
    assign w_can_load  = !r_vfu_valid || vfu_ready;
    assign w_vfu_fire  = r_vfu_valid && vfu_ready;

    // The beat sitting in the slice has not been counted yet, so it is added
    // here to keep the total in flight within MAX_OUTSTANDING.
    assign w_credit_ok = ({1'b0, r_outstanding} + {4'd0, r_vfu_valid}) < c_MAX;
    assign w_can_issue = w_can_load && w_credit_ok;

    // Round-robin search: scan from the pointer upward with wrap; iterating
    // from the farthest offset down lets the nearest requester win.
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_grant = r_rr_ptr;
        w_sum      = '0;
        for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
            w_sum = {1'b0, r_rr_ptr} + c_SUM_W'(k);
            if (w_sum >= c_NUM_SLOTS) begin
                w_sum = w_sum - c_NUM_SLOTS;
            end
            if (req_valid[w_sum[c_TAG_W-1:0]]) begin
                w_rr_found = 1'b1;
                w_rr_grant = w_sum[c_TAG_W-1:0];
            end
        end
    end

`ifdef VFU_ARB_LOCK_EN
    // Lock tracking: the slot granted last may hold the grant while it keeps
    // both valid and lock asserted.
    logic               r_locked;
    logic [c_TAG_W-1:0] r_lock_slot;
    logic               w_lock_hold;

    assign w_lock_hold = r_locked && req_valid[r_lock_slot] && req_lock[r_lock_slot];
    assign w_found     = w_lock_hold || w_rr_found;
    assign w_grant     = w_lock_hold ? r_lock_slot : w_rr_grant;

    // Lock state follows the lock bit of each accepted beat.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_locked    <= 1'b0;
            r_lock_slot <= '0;
        end else if (w_accept) begin
            r_locked    <= req_lock[w_grant];
            r_lock_slot <= w_grant;
        end
    end
`else
    assign w_found = w_rr_found;
    assign w_grant = w_rr_grant;
`endif

    assign w_accept = w_found && w_can_issue;

    // Only the granted slot sees ready, and only when a beat can be taken.
    always_comb begin
        w_req_ready = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (w_accept && (w_grant == c_TAG_W'(i))) begin
                w_req_ready[i] = 1'b1;
            end
        end
    end

    // Ready is forced low while reset is held so every output reads zero.
    assign req_ready = reset ? w_req_ready : '0;

    assign w_grant_bits = req_bits[int'(w_grant) * REQ_W +: REQ_W];

    // Pointer moves to the slot after the one just served, wrapping at the top.
    always_comb begin
        w_ptr_next = r_rr_ptr;
        if (w_accept) begin
            if (w_grant == c_TAG_W'(NUM_SLOTS - 1)) begin
                w_ptr_next = '0;
            end else begin
                w_ptr_next = w_grant + c_TAG_W'(1);
            end
`ifdef VFU_ARB_LOCK_EN
            // A locked beat keeps the pointer where it is.
            if (req_lock[w_grant]) begin
                w_ptr_next = r_rr_ptr;
            end
`endif
        end
    end

    // Output register slice: load on accept, hold while stalled, empty on drain.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_vfu_valid <= 1'b0;
            r_vfu_bits  <= '0;
            r_vfu_tag   <= '0;
            r_rr_ptr    <= '0;
        end else begin
            r_rr_ptr <= w_ptr_next;
            if (w_accept) begin
                r_vfu_valid <= 1'b1;
                r_vfu_bits  <= w_grant_bits;
                r_vfu_tag   <= w_grant;
            end else if (vfu_ready) begin
                r_vfu_valid <= 1'b0;
            end
        end
    end

    // A response with nothing in flight is flagged and does not decrement.
    assign w_rsp_underflow = rsp_valid && (r_outstanding == 4'd0);
    assign w_rsp_dec       = rsp_valid && (r_outstanding != 4'd0);

    // In-flight counter: issue handshake adds one, response removes one.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_outstanding   <= 4'd0;
            r_err_underflow <= 1'b0;
        end else begin
            case ({w_vfu_fire, w_rsp_dec})
                2'b10:   r_outstanding <= r_outstanding + 4'd1;
                2'b01:   r_outstanding <= r_outstanding - 4'd1;
                default: r_outstanding <= r_outstanding;
            endcase
            if (w_rsp_underflow) begin
                r_err_underflow <= 1'b1;
            end
        end
    end

    // One-hot decode of the response tag.
    always_comb begin
        w_rsp_onehot = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (rsp_valid && (rsp_tag == c_TAG_W'(i))) begin
                w_rsp_onehot[i] = 1'b1;
            end
        end
    end

    // Response stage: register the routed valid and the shared data bus.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_slot_rsp_valid <= '0;
            r_slot_rsp_data  <= '0;
        end else begin
            r_slot_rsp_valid <= w_rsp_onehot;
            r_slot_rsp_data  <= rsp_data;
        end
    end

    assign vfu_valid      = r_vfu_valid;
    assign vfu_bits       = r_vfu_bits;
    assign vfu_tag        = r_vfu_tag;
    assign outstanding    = r_outstanding;
    assign err_underflow  = r_err_underflow;
    assign slot_rsp_valid = r_slot_rsp_valid;
    assign slot_rsp_data  = r_slot_rsp_data;

endmodule
`default_nettype wire

// File: tb/tb_vfu_slot_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_vfu_slot_arbiter
// Description : Directed self-checking bench for vfu_slot_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vfu_slot_arbiter;

    localparam int NUM_SLOTS       = 4;
    localparam int REQ_W           = 200;
    localparam int RSP_W           = 33;
    localparam int MAX_OUTSTANDING = 4;

    logic                       clock = 1'b0;
    logic                       reset = 1'b0;
    logic [NUM_SLOTS-1:0]       req_valid = '0;
    logic [NUM_SLOTS-1:0]       req_ready;
    logic [NUM_SLOTS*REQ_W-1:0] req_bits = '0;
    logic [NUM_SLOTS-1:0]       req_lock = '0;
    logic                       vfu_valid;
    logic                       vfu_ready = 1'b0;
    logic [REQ_W-1:0]           vfu_bits;
    logic [1:0]                 vfu_tag;
    logic                       rsp_valid = 1'b0;
    logic [1:0]                 rsp_tag = '0;
    logic [RSP_W-1:0]           rsp_data = '0;
    logic [NUM_SLOTS-1:0]       slot_rsp_valid;
    logic [RSP_W-1:0]           slot_rsp_data;
    logic [3:0]                 outstanding;
    logic                       err_underflow;

    int total = 0;
    int bad   = 0;

    vfu_slot_arbiter #(
        .NUM_SLOTS       (NUM_SLOTS),
        .REQ_W           (REQ_W),
        .RSP_W           (RSP_W),
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_bits       (req_bits),
`ifdef VFU_ARB_LOCK_EN
        .req_lock       (req_lock),
`endif
        .vfu_valid      (vfu_valid),
        .vfu_ready      (vfu_ready),
        .vfu_bits       (vfu_bits),
        .vfu_tag        (vfu_tag),
        .rsp_valid      (rsp_valid),
        .rsp_tag        (rsp_tag),
        .rsp_data       (rsp_data),
        .slot_rsp_valid (slot_rsp_valid),
        .slot_rsp_data  (slot_rsp_data),
        .outstanding    (outstanding),
        .err_underflow  (err_underflow)
    );

    always #5 clock = ~clock;

    // Distinct, recognisable payload per slot.
    function automatic logic [REQ_W-1:0] payload(input int slot);
        logic [31:0] word;
        logic [7:0]  head;
        word = 32'hC0DE_0000 + 32'(slot) * 32'h0001_1111;
        head = 8'hA0 + 8'(slot);
        return {head, {6{word}}};
    endfunction

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset;
        req_valid = '0;
        vfu_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_tag   = '0;
        rsp_data  = '0;
        reset     = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
    endtask

    task automatic test_reset;
        reset     = 1'b0;
        req_valid = 4'b1111;
        repeat (2) tick();
        total++; if (vfu_valid !== 1'b0) begin bad++; $display("FAIL reset_vfu_valid got=%b want=0", vfu_valid); end
        total++; if (vfu_bits !== '0) begin bad++; $display("FAIL reset_vfu_bits got=%h want=0", vfu_bits); end
        total++; if (vfu_tag !== 2'd0) begin bad++; $display("FAIL reset_vfu_tag got=%0d want=0", vfu_tag); end
        total++; if (slot_rsp_valid !== 4'b0000) begin bad++; $display("FAIL reset_slot_rsp_valid got=%b want=0000", slot_rsp_valid); end
        total++; if (slot_rsp_data !== '0) begin bad++; $display("FAIL reset_slot_rsp_data got=%h want=0", slot_rsp_data); end
        total++; if (outstanding !== 4'd0) begin bad++; $display("FAIL reset_outstanding got=%0d want=0", outstanding); end
        total++; if (err_underflow !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err_underflow); end
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_req_ready got=%b want=0000", req_ready); end
        req_valid = '0;
    endtask

    task automatic test_single_slot;
        do_reset();
        req_valid = 4'b0100;
        vfu_ready = 1'b1;
        #1;
        total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL single_req_ready got=%b want=0100", req_ready); end
        total++; if (vfu_valid !== 1'b0) begin bad++; $display("FAIL single_pre_valid got=%b want=0", vfu_valid); end
        tick();
        req_valid = '0;
        total++; if (vfu_valid !== 1'b1) begin bad++; $display("FAIL single_vfu_valid got=%b want=1", vfu_valid); end
        total++; if (vfu_tag !== 2'd2) begin bad++; $display("FAIL single_vfu_tag got=%0d want=2", vfu_tag); end
        total++; if (vfu_bits !== payload(2)) begin bad++; $display("FAIL single_vfu_bits got=%h want=%h", vfu_bits, payload(2)); end
        tick();
        total++; if (vfu_valid !== 1'b0) begin bad++; $display("FAIL single_drain got=%b want=0", vfu_valid); end
        total++; if (outstanding !== 4'd1) begin bad++; $display("FAIL single_outstanding got=%0d want=1", outstanding); end
        rsp_valid = 1'b1;
        rsp_tag   = 2'd2;
        rsp_data  = 33'h1_2345_6789;
        tick();
        rsp_valid = 1'b0;
        total++; if (slot_rsp_valid !== 4'b0100) begin bad++; $display("FAIL single_rsp_route got=%b want=0100", slot_rsp_valid); end
        total++; if (slot_rsp_data !== 33'h1_2345_6789) begin bad++; $display("FAIL single_rsp_data got=%h want=123456789", slot_rsp_data); end
        total++; if (outstanding !== 4'd0) begin bad++; $display("FAIL single_rsp_dec got=%0d want=0", outstanding); end
    endtask

    task automatic test_round_robin;
        logic [NUM_SLOTS-1:0] exp_ready;
        logic [REQ_W-1:0]     exp_bits;
        logic [1:0]           exp_tag;
        do_reset();
        req_valid = 4'b1111;
        vfu_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            exp_tag   = 2'((k - 1) % 4);
            exp_ready = 4'b0001 << exp_tag;
            exp_bits  = payload((k - 1) % 4);
            #1;
            total++; if (req_ready !== exp_ready) begin bad++; $display("FAIL rr_req_ready beat=%0d got=%b want=%b", k, req_ready, exp_ready); end
            tick();
            total++; if (vfu_valid !== 1'b1) begin bad++; $display("FAIL rr_vfu_valid beat=%0d got=%b want=1", k, vfu_valid); end
            total++; if (vfu_tag !== exp_tag) begin bad++; $display("FAIL rr_vfu_tag beat=%0d got=%0d want=%0d", k, vfu_tag, exp_tag); end
            total++; if (vfu_bits !== exp_bits) begin bad++; $display("FAIL rr_vfu_bits beat=%0d got=%h want=%h", k, vfu_bits, exp_bits); end
            if (k >= 2) begin
                rsp_valid = 1'b1;
                rsp_tag   = 2'((k - 2) % 4);
            end
        end
        total++; if (outstanding !== 4'd1) begin bad++; $display("FAIL rr_outstanding got=%0d want=1", outstanding); end
        req_valid = '0;
        rsp_valid = 1'b0;
    endtask

    task automatic test_credit_limit;
        int grants;
        grants = 0;
        do_reset();
        req_valid = 4'b0001;
        vfu_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            if (req_ready[0]) grants++;
            tick();
        end
        total++; if (grants !== 4) begin bad++; $display("FAIL credit_grants got=%0d want=4", grants); end
        total++; if (outstanding !== 4'd4) begin bad++; $display("FAIL credit_outstanding got=%0d want=4", outstanding); end
        total++; if (vfu_valid !== 1'b0) begin bad++; $display("FAIL credit_vfu_valid got=%b want=0", vfu_valid); end
        rsp_valid = 1'b1;
        rsp_tag   = 2'd0;
        #1;
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL credit_full_ready got=%b want=0000", req_ready); end
        tick();
        rsp_valid = 1'b0;
        total++; if (outstanding !== 4'd3) begin bad++; $display("FAIL credit_after_rsp got=%0d want=3", outstanding); end
        #1;
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL credit_reissue_ready got=%b want=0001", req_ready); end
        tick();
        total++; if (vfu_valid !== 1'b1) begin bad++; $display("FAIL credit_reissue_valid got=%b want=1", vfu_valid); end
        #1;
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL credit_refull_ready got=%b want=0000", req_ready); end
        tick();
        total++; if (outstanding !== 4'd4) begin bad++; $display("FAIL credit_refull_count got=%0d want=4", outstanding); end
        req_valid = '0;
    endtask

    task automatic test_stall_and_overlap;
        do_reset();
        req_valid = 4'b0001;
        vfu_ready = 1'b0;
        #1;
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL stall_first_ready got=%b want=0001", req_ready); end
        tick();
        req_valid = 4'b0010;
        for (int k = 0; k < 5; k++) begin
            #1;
            total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL stall_req_ready cyc=%0d got=%b want=0000", k, req_ready); end
            tick();
            total++; if (vfu_valid !== 1'b1) begin bad++; $display("FAIL stall_valid cyc=%0d got=%b want=1", k, vfu_valid); end
            total++; if (vfu_tag !== 2'd0) begin bad++; $display("FAIL stall_tag cyc=%0d got=%0d want=0", k, vfu_tag); end
            total++; if (vfu_bits !== payload(0)) begin bad++; $display("FAIL stall_bits cyc=%0d got=%h want=%h", k, vfu_bits, payload(0)); end
        end
        vfu_ready = 1'b1;
        #1;
        total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL stall_release_ready got=%b want=0010", req_ready); end
        tick();
        req_valid = '0;
        total++; if (outstanding !== 4'd1) begin bad++; $display("FAIL stall_outstanding got=%0d want=1", outstanding); end
        total++; if (vfu_tag !== 2'd1) begin bad++; $display("FAIL stall_next_tag got=%0d want=1", vfu_tag); end
        rsp_valid = 1'b1;
        rsp_tag   = 2'd0;
        rsp_data  = 33'h0_0000_00AA;
        tick();
        rsp_valid = 1'b0;
        total++; if (outstanding !== 4'd1) begin bad++; $display("FAIL overlap_outstanding got=%0d want=1", outstanding); end
        total++; if (vfu_valid !== 1'b0) begin bad++; $display("FAIL overlap_drain got=%b want=0", vfu_valid); end
        total++; if (slot_rsp_valid !== 4'b0001) begin bad++; $display("FAIL overlap_route got=%b want=0001", slot_rsp_valid); end
    endtask

    task automatic test_underflow;
        do_reset();
        rsp_valid = 1'b1;
        rsp_tag   = 2'd3;
        rsp_data  = 33'h1_ABCD_EF01;
        tick();
        rsp_valid = 1'b0;
        total++; if (slot_rsp_valid !== 4'b1000) begin bad++; $display("FAIL uf_route got=%b want=1000", slot_rsp_valid); end
        total++; if (slot_rsp_data !== 33'h1_ABCD_EF01) begin bad++; $display("FAIL uf_data got=%h want=1abcdef01", slot_rsp_data); end
        total++; if (err_underflow !== 1'b1) begin bad++; $display("FAIL uf_err got=%b want=1", err_underflow); end
        total++; if (outstanding !== 4'd0) begin bad++; $display("FAIL uf_outstanding got=%0d want=0", outstanding); end
        repeat (3) tick();
        total++; if (err_underflow !== 1'b1) begin bad++; $display("FAIL uf_sticky got=%b want=1", err_underflow); end
        total++; if (slot_rsp_valid !== 4'b0000) begin bad++; $display("FAIL uf_route_clear got=%b want=0000", slot_rsp_valid); end
    endtask

    task automatic test_reset_mid;
        do_reset();
        req_valid = 4'b0001;
        vfu_ready = 1'b1;
        repeat (4) tick();
        vfu_ready = 1'b0;
        req_valid = 4'b1111;
        repeat (2) tick();
        total++; if (outstanding !== 4'd3) begin bad++; $display("FAIL mid_outstanding got=%0d want=3", outstanding); end
        total++; if (vfu_valid !== 1'b1) begin bad++; $display("FAIL mid_vfu_valid got=%b want=1", vfu_valid); end
        #2;
        reset = 1'b0;
        #1;
        total++; if (vfu_valid !== 1'b0) begin bad++; $display("FAIL mid_async_valid got=%b want=0", vfu_valid); end
        total++; if (outstanding !== 4'd0) begin bad++; $display("FAIL mid_async_outstanding got=%0d want=0", outstanding); end
        total++; if (vfu_bits !== '0) begin bad++; $display("FAIL mid_async_bits got=%h want=0", vfu_bits); end
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL mid_async_ready got=%b want=0000", req_ready); end
        #1;
        reset     = 1'b1;
        vfu_ready = 1'b1;
        #1;
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL mid_first_grant got=%b want=0001", req_ready); end
        tick();
        total++; if (vfu_tag !== 2'd0) begin bad++; $display("FAIL mid_first_tag got=%0d want=0", vfu_tag); end
        total++; if (vfu_valid !== 1'b1) begin bad++; $display("FAIL mid_first_valid got=%b want=1", vfu_valid); end
        req_valid = '0;
    endtask

    initial begin
        req_bits = {payload(3), payload(2), payload(1), payload(0)};
        test_reset();
        test_single_slot();
        test_round_robin();
        test_credit_limit();
        test_stall_and_overlap();
        test_underflow();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vfu_slot_arbiter.md
Name: vfu_slot_arbiter

Overview:
- Shares one vector functional unit (VFU) issue port between NUM_SLOTS lane slot requesters. Sits between the lane slot pipelines and the VFU input.
- Round-robin grant feeds a registered output stage. Tag-based credit tracking bounds in-flight requests. Returning VFU responses are routed back to the originating slot by tag.

Parameters:
- NUM_SLOTS, 4, number of requesting slots; slot index travels as the 2-bit tag.
- REQ_W, 200, packed SlotRequestToVFU payload width, tag field excluded.
- RSP_W, 33, VFU response data width.
- MAX_OUTSTANDING, 4, global in-flight request limit, 1..15.

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  NUM_SLOTS  per-slot request valid
- req_ready  out  NUM_SLOTS  per-slot request accepted this cycle
- req_bits  in  NUM_SLOTS*REQ_W  per-slot payload; slot i at bits [i*REQ_W +: REQ_W]
- vfu_valid  out  1  registered request to VFU
- vfu_ready  in  1  VFU accepts
- vfu_bits  out  REQ_W  registered payload
- vfu_tag  out  2  originating slot index
- rsp_valid  in  1  VFU response valid; always accepted
- rsp_tag  in  2  response slot index
- rsp_data  in  RSP_W  response data
- slot_rsp_valid  out  NUM_SLOTS  one-hot response to slot, registered
- slot_rsp_data  out  RSP_W  registered response data, shared by all slots
- outstanding  out  4  current in-flight count
- err_underflow  out  1  sticky: response arrived with outstanding==0

Behaviour:
- Reset values: vfu_valid=0, vfu_bits=0, vfu_tag=0, slot_rsp_valid=0, slot_rsp_data=0, outstanding=0, err_underflow=0. RR pointer = slot 0.
- can_load = !vfu_valid || vfu_ready.
- can_issue = can_load && (outstanding + vfu_valid_pending < MAX_OUTSTANDING). A request counts toward outstanding only when the vfu_valid && vfu_ready handshake fires.
- Grant: first slot with req_valid, searching from the RR pointer upward and wrapping at NUM_SLOTS-1 -> 0.
- req_ready[g] = can_issue for the granted slot only; all other bits 0. No combinational path from req_ready to req_valid.
- On req_valid[g] && req_ready[g], next cycle: vfu_valid=1, vfu_bits = slot g payload, vfu_tag=g, RR pointer = (g+1) mod NUM_SLOTS.
- Register-slice latency 1 cycle. Full throughput when vfu_ready is held high and credits are available.
- vfu_valid && !vfu_ready holds vfu_bits and vfu_tag stable. No new grant is issued.
- vfu_valid drops when the handshake fires with no new grant.
- outstanding: +1 on VFU handshake, -1 on rsp_valid; both in the same cycle leave it unchanged. Never exceeds MAX_OUTSTANDING.
- Issue stalls when outstanding + (vfu_valid?1:0) == MAX_OUTSTANDING.
- Response routing, 1 cycle: slot_rsp_valid = one-hot(rsp_tag) when rsp_valid, else 0; slot_rsp_data = rsp_data.
- rsp_valid with outstanding==0: outstanding stays 0, err_underflow set. Only reset clears it.
- Reset asserted mid-transfer: everything returns to reset values immediately. In-flight requests are discarded; the upstream must re-issue.
- No requesters: RR pointer unchanged, vfu_valid falls after the pending handshake.

Optional Feature:
- VFU_ARB_LOCK_EN. Adds input req_lock[NUM_SLOTS].
- Defined: while the slot last granted holds req_lock high and req_valid high, it keeps the grant. The RR pointer does not advance; it is used for back-to-back executeIndex groups. Lock releases on the first accepted beat with req_lock low. Credit limits still apply.
- Undefined: the port is absent and arbitration is pure round-robin.

Test Plan:
- Single slot 2 valid, vfu_ready=1 -> vfu_valid rises 1 cycle after req_ready[2], vfu_tag=2, payload matches bit-exact.
- All 4 slots valid continuously, vfu_ready=1, fast responses -> grant order 0,1,2,3,0,1,... with one issue per cycle.
- MAX_OUTSTANDING=4, no responses -> exactly 4 handshakes, then req_ready all 0 and outstanding=4. One rsp_valid -> one more issue.
- vfu_ready=0 for 5 cycles with vfu_valid=1 -> vfu_bits and vfu_tag stable, req_ready=0. Same-cycle issue + response -> outstanding unchanged.
- rsp_valid with rsp_tag=3 -> next cycle slot_rsp_valid=4'b1000 with data echoed. rsp_valid at outstanding=0 -> err_underflow=1 and sticky.
- reset pulled low mid-stall with outstanding=3 -> all outputs 0 asynchronously; after release, slot 0 is granted first.
